hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a six-stage in-order core (PC/IF/ID/EX/MEM/WB).
// Tracks the destinations of the instructions in EX and MEM with a two-entry
// scoreboard. It detects load-use hazards between ID and EX and produces the
// freeze vector. Flush, multi-cycle EX and load-use hazards are arbitrated in
// that priority order. The controller also counts stalled cycles, saturating
// the count at its maximum.
// ----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,            // asynchronous, active-low
   // ID stage instruction
   input  logic        id_valid_i,
   input  logic        reg1_read_i,
   input  logic        reg2_read_i,
   input  logic [4:0]  reg1_addr_i,
   input  logic [4:0]  reg2_addr_i,
   input  logic        wreg_i,
   input  logic [4:0]  wd_i,
   input  logic        is_load_i,
   // stall / flush requests
   input  logic        ex_stallreq_i,
   input  logic        flush_i,
   // control outputs
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cnt_o
);

   // -------------------------------------------------------------------------
   // Types and constants
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_LOAD_STALL = 2'd1,
      S_EX_BUSY    = 2'd2,
      S_FLUSH      = 2'd3
   } state_t;

   // One scoreboard entry: the destination register of an in-flight instruction.
   typedef struct packed {
      logic       valid;
      logic [4:0] addr;
      logic       load;
   } slot_t;

   // Freeze vectors: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
   localparam logic [5:0]  STALL_NONE = 6'b000000;
   localparam logic [5:0]  STALL_LOAD = 6'b000111;  // hold PC/IF/ID, bubble into EX
   localparam logic [5:0]  STALL_EX   = 6'b001111;  // hold PC..EX, bubble into MEM
   localparam slot_t       SLOT_EMPTY = '{valid: 1'b0, addr: 5'd0, load: 1'b0};
   localparam logic [15:0] CNT_MAX    = 16'hFFFF;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t      r_state;
   logic        r_flush;
   slot_t       r_ex_slot;
   slot_t       r_mem_slot;
   logic [15:0] r_stall_cnt;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   logic        w_rs1_match;
   logic        w_rs2_match;
   logic        w_load_use;
   logic [5:0]  w_stall;
   state_t      w_next_state;
   slot_t       w_id_slot;

   // Load-use detection: only the EX slot matters. Results from the MEM slot
   // reach ID through forwarding, so that slot never causes a stall.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_rs1_match = 1'b0;
      w_rs2_match = 1'b0;
      w_load_use  = 1'b0;
      w_rs1_match = reg1_read_i && (reg1_addr_i == r_ex_slot.addr);
      w_rs2_match = reg2_read_i && (reg2_addr_i == r_ex_slot.addr);
      // Register 0 is hard-wired to zero, so a load targeting it is never a hazard.
      w_load_use  = id_valid_i && r_ex_slot.valid && r_ex_slot.load &&
                    (r_ex_slot.addr != 5'd0) && (w_rs1_match || w_rs2_match);
   end

   // Freeze vector: a flush (requested now or in progress) wins over any stall.
   always_comb begin
      w_stall = STALL_NONE;
      // Gating with reset keeps the freeze vector at zero while reset is asserted,
      // even if a requester is still driving ex_stallreq_i.
      if (!rst || flush_i || (r_state == S_FLUSH)) begin
         w_stall = STALL_NONE;
      end else if (ex_stallreq_i) begin
         w_stall = STALL_EX;
      end else if (w_load_use) begin
         w_stall = STALL_LOAD;
      end
   end

   // Next-state priority: flush > EX busy > load-use hazard > idle.
   always_comb begin
      w_next_state = S_IDLE;
      if (flush_i) begin
         w_next_state = S_FLUSH;
      end else if (ex_stallreq_i) begin
         w_next_state = S_EX_BUSY;
      end else if (w_load_use) begin
         w_next_state = S_LOAD_STALL;
      end
   end

   // Scoreboard entry for the instruction currently leaving ID.
   always_comb begin
      w_id_slot       = SLOT_EMPTY;
      w_id_slot.valid = id_valid_i & wreg_i;
      w_id_slot.addr  = wd_i;
      w_id_slot.load  = is_load_i;
   end

   // -------------------------------------------------------------------------
   // Sequential logic
   // -------------------------------------------------------------------------

   // FSM with registered flush pulse; FLUSH lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_flush <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         r_state <= w_next_state;
         r_flush <= (w_next_state == S_FLUSH);
      end
   end

   // Scoreboard advance: normal flow, load bubble, EX hold, or flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the scoreboard is reset explicitly; stale valid bits would create phantom hazards.
         r_ex_slot  <= SLOT_EMPTY;
         r_mem_slot <= SLOT_EMPTY;
      end else if (flush_i) begin
         r_ex_slot  <= SLOT_EMPTY;
         r_mem_slot <= SLOT_EMPTY;
      end else begin
         case (w_stall)
            STALL_EX: begin
               // EX is frozen; MEM receives a bubble.
               r_ex_slot  <= r_ex_slot;
               r_mem_slot <= SLOT_EMPTY;
            end
            STALL_LOAD: begin
               // The load advances to MEM while a bubble enters EX.
               r_ex_slot  <= SLOT_EMPTY;
               r_mem_slot <= r_ex_slot;
            end
            default: begin
               r_ex_slot  <= w_id_slot;
               r_mem_slot <= r_ex_slot;
            end
         endcase
      end
   end

   // Stalled-cycle counter; sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= 16'd0;
      end else if ((w_stall != STALL_NONE) && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign stall_o     = w_stall;
   assign flush_o     = r_flush;
   assign state_o     = r_state;
   assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid_i;
   logic        reg1_read_i;
   logic        reg2_read_i;
   logic [4:0]  reg1_addr_i;
   logic [4:0]  reg2_addr_i;
   logic        wreg_i;
   logic [4:0]  wd_i;
   logic        is_load_i;
   logic        ex_stallreq_i;
   logic        flush_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o;

   int total = 0;
   int bad   = 0;

   hazard_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid_i    (id_valid_i),
      .reg1_read_i   (reg1_read_i),
      .reg2_read_i   (reg2_read_i),
      .reg1_addr_i   (reg1_addr_i),
      .reg2_addr_i   (reg2_addr_i),
      .wreg_i        (wreg_i),
      .wd_i          (wd_i),
      .is_load_i     (is_load_i),
      .ex_stallreq_i (ex_stallreq_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .state_o       (state_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2,
                         input logic wr, input logic [4:0] wd, input logic ld);
      id_valid_i  = v;
      reg1_read_i = r1;
      reg1_addr_i = a1;
      reg2_read_i = r2;
      reg2_addr_i = a2;
      wreg_i      = wr;
      wd_i        = wd;
      is_load_i   = ld;
   endtask

   task automatic clear_id();
      set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      rst           = 1'b0;
      ex_stallreq_i = 1'b0;
      flush_i       = 1'b0;
      clear_id();

      // ---------------- reset state ----------------
      #2;
      check("rst_stall", 16'(stall_o), 16'h0);
      check("rst_state", 16'(state_o), 16'd0);
      check("rst_flush", 16'(flush_o), 16'd0);
      check("rst_cnt",   stall_cnt_o,  16'd0);
      #10 rst = 1'b1;                       // release between edges
      tick();

      // ---------------- load r3 then reader of r3 ----------------
      set_id(1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 1);   // lw r3
      tick();
      set_id(1, 1, 5'd3, 0, 5'd0, 1, 5'd5, 0);   // add r5 <- r3
      #1;
      check("lu_stall",       16'(stall_o), 16'h0007);
      tick();
      check("lu_state",       16'(state_o), 16'd1);
      check("lu_bubble",      16'(stall_o), 16'h0);
      check("lu_cnt",         stall_cnt_o,  16'd1);
      tick();                                   // reader proceeds to EX
      check("lu_back_idle",   16'(state_o), 16'd0);

      // ---------------- load r0 then reader of r0 ----------------
      set_id(1, 0, 5'd0, 0, 5'd0, 1, 5'd0, 1);   // lw r0
      tick();
      set_id(1, 1, 5'd0, 1, 5'd0, 1, 5'd7, 0);   // reads r0 on both ports
      #1;
      check("r0_stall",       16'(stall_o), 16'h0);
      tick();
      check("r0_state",       16'(state_o), 16'd0);
      check("r0_cnt",         stall_cnt_o,  16'd1);

      // ---------------- reg2 port hazard, gated by id_valid ----------------
      set_id(1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 1);   // lw r9
      tick();
      set_id(0, 0, 5'd0, 1, 5'd9, 0, 5'd0, 0);   // reader of r9, not yet valid
      #1;
      check("r2_invalid_id",  16'(stall_o), 16'h0);
      id_valid_i = 1'b1;
      #1;
      check("r2_stall",       16'(stall_o), 16'h0007);
      tick();
      check("r2_state",       16'(state_o), 16'd1);
      check("r2_cnt",         stall_cnt_o,  16'd2);
      clear_id();
      tick();

      // ---------------- EX busy 4 cycles with hazard underneath ----------------
      set_id(1, 0, 5'd0, 0, 5'd0, 1, 5'd6, 1);   // lw r6
      tick();
      set_id(1, 1, 5'd6, 0, 5'd0, 1, 5'd2, 0);   // reader of r6
      ex_stallreq_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("exb_stall%0d", i), 16'(stall_o), 16'h000F);
         tick();
         check($sformatf("exb_state%0d", i), 16'(state_o), 16'd2);
      end
      ex_stallreq_i = 1'b0;
      #1;
      check("exb_load_stall", 16'(stall_o), 16'h0007);
      tick();
      check("exb_ls_state",   16'(state_o), 16'd1);
      check("exb_ls_bubble",  16'(stall_o), 16'h0);
      check("exb_cnt",        stall_cnt_o,  16'd7);
      clear_id();
      tick();

      // ---------------- flush beats EX busy and pending load ----------------
      set_id(1, 0, 5'd0, 0, 5'd0, 1, 5'd8, 1);   // lw r8
      tick();
      set_id(1, 1, 5'd8, 0, 5'd0, 0, 5'd0, 0);   // reader of r8
      ex_stallreq_i = 1'b1;
      flush_i       = 1'b1;
      #1;
      check("fl_stall",       16'(stall_o), 16'h0);
      tick();
      check("fl_state",       16'(state_o), 16'd3);
      check("fl_flush_o",     16'(flush_o), 16'd1);
      flush_i = 1'b0;                           // EX still busy, reader still in ID
      #1;
      check("fl_state_stall", 16'(stall_o), 16'h0);
      tick();                                   // slots were cleared: no hazard
      check("fl_to_exbusy",   16'(state_o), 16'd2);
      check("fl_pulse_end",   16'(flush_o), 16'd0);
      ex_stallreq_i = 1'b0;
      #1;
      check("fl_no_hazard",   16'(stall_o), 16'h0);
      check("fl_cnt",         stall_cnt_o,  16'd7);
      clear_id();
      tick();
      check("fl_idle",        16'(state_o), 16'd0);

      // ---------------- counter saturation ----------------
      ex_stallreq_i = 1'b1;
      for (int i = 0; i < 16'hFFFD - 7; i++) tick();
      check("sat_fffd",       stall_cnt_o,  16'hFFFD);
      tick();
      check("sat_fffe",       stall_cnt_o,  16'hFFFE);
      tick();
      check("sat_ffff",       stall_cnt_o,  16'hFFFF);
      tick();
      tick();
      check("sat_hold",       stall_cnt_o,  16'hFFFF);

      // ---------------- async reset during EX busy ----------------
      ex_stallreq_i = 1'b0;
      set_id(1, 0, 5'd0, 0, 5'd0, 1, 5'd12, 1);  // lw r12
      tick();
      set_id(1, 1, 5'd12, 0, 5'd0, 0, 5'd0, 0);  // reader of r12
      ex_stallreq_i = 1'b1;
      tick();
      check("ar_pre_state",   16'(state_o), 16'd2);
      #2 rst = 1'b0;                            // mid-cycle, no clock edge
      #1;
      check("ar_stall",       16'(stall_o), 16'h0);
      check("ar_state",       16'(state_o), 16'd0);
      check("ar_flush",       16'(flush_o), 16'd0);
      check("ar_cnt",         stall_cnt_o,  16'd0);
      ex_stallreq_i = 1'b0;
      #1 rst = 1'b1;                            // reader of r12 still in ID
      #1;
      check("ar_empty_sb",    16'(stall_o), 16'h0);
      tick();
      check("ar_post_state",  16'(state_o), 16'd0);
      check("ar_post_cnt",    stall_cnt_o,  16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Backstop so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
